// File: rtl/bcd_display_mux_pkg.sv
// Shared constants for the multiplexed BCD 7-segment display.
// Contents: default digit count, glyph width and the segment glyphs
// in {g,f,e,d,c,b,a} order, active-high.
package bcd_display_mux_pkg;

   localparam int unsigned DIGITS_DEFAULT = 5;
   localparam int unsigned SEG_W          = 7;

   localparam logic [SEG_W-1:0] SEG_0    = 7'h3F;
   localparam logic [SEG_W-1:0] SEG_1    = 7'h06;
   localparam logic [SEG_W-1:0] SEG_2    = 7'h5B;
   localparam logic [SEG_W-1:0] SEG_3    = 7'h4F;
   localparam logic [SEG_W-1:0] SEG_4    = 7'h66;
   localparam logic [SEG_W-1:0] SEG_5    = 7'h6D;
   localparam logic [SEG_W-1:0] SEG_6    = 7'h7D;
   localparam logic [SEG_W-1:0] SEG_7    = 7'h07;
   localparam logic [SEG_W-1:0] SEG_8    = 7'h7F;
   localparam logic [SEG_W-1:0] SEG_9    = 7'h6F;
   localparam logic [SEG_W-1:0] SEG_DASH = 7'h40;
   localparam logic [SEG_W-1:0] SEG_OFF  = 7'h00;

endpackage

// File: rtl/bcd_segment_decoder.sv
// Combinational BCD nibble to 7-segment glyph decoder.
// Ports:
//   i_nibble  - BCD digit; values 10..15 are treated as invalid
//   o_glyph_c - {g,f,e,d,c,b,a} active-high glyph; dash for invalid nibbles
module bcd_segment_decoder
   import bcd_display_mux_pkg::*;
(
   input  logic [3:0]       i_nibble,
   output logic [SEG_W-1:0] o_glyph_c
);

   always_comb begin
      o_glyph_c = SEG_DASH;
      case (i_nibble)
         4'd0:    o_glyph_c = SEG_0;
         4'd1:    o_glyph_c = SEG_1;
         4'd2:    o_glyph_c = SEG_2;
         4'd3:    o_glyph_c = SEG_3;
         4'd4:    o_glyph_c = SEG_4;
         4'd5:    o_glyph_c = SEG_5;
         4'd6:    o_glyph_c = SEG_6;
         4'd7:    o_glyph_c = SEG_7;
         4'd8:    o_glyph_c = SEG_8;
         4'd9:    o_glyph_c = SEG_9;
         default: o_glyph_c = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/bcd_display_mux.sv
// Time-multiplexed 7-segment driver for a packed BCD word.
// New values are buffered and only applied on the last cycle of a scan frame,
// so a frame is always drawn from one consistent value.
// Ports:
//   Clock, Reset - system clock, synchronous active-high reset
//   BCD_i        - packed BCD, digit 0 (units) in [3:0]
//   Load_i       - one-cycle strobe capturing BCD_i
//   LZBlank_i    - 1 = suppress leading zeros (sampled live)
//   Anodes_o     - one-hot active-high digit enable (registered)
//   Segments_o   - {g,f,e,d,c,b,a} active-high (registered)
//   Update_o     - one-cycle pulse when a new value reaches the display
module bcd_display_mux
   import bcd_display_mux_pkg::*;
#(
   parameter int unsigned DIGITS       = DIGITS_DEFAULT,
   parameter int unsigned DIGIT_CYCLES = 200,
   parameter int unsigned GHOST_CYCLES = 4
) (
   input  logic                Clock,
   input  logic                Reset,
   input  logic [4*DIGITS-1:0] BCD_i,
   input  logic                Load_i,
   input  logic                LZBlank_i,
   output logic [DIGITS-1:0]   Anodes_o,
   output logic [SEG_W-1:0]    Segments_o,
   output logic                Update_o
);

   localparam int unsigned BCD_W  = 4 * DIGITS;
   localparam int unsigned SLOT_W = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
   localparam int unsigned IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(DIGIT_CYCLES - 1);
   localparam logic [SLOT_W-1:0] SLOT_GHOST = SLOT_W'(GHOST_CYCLES);
   localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(DIGITS - 1);

   logic [SLOT_W-1:0] r_slot_cnt;
   logic [IDX_W-1:0]  r_digit_idx;
   logic [BCD_W-1:0]  r_pending;
   logic              r_pending_valid;
   logic [BCD_W-1:0]  r_display;
   logic [DIGITS-1:0] r_anodes;
   logic [SEG_W-1:0]  r_segments;
   logic              r_update;

   logic              w_slot_end;
   logic              w_boundary;
   logic              w_ghost;
   logic [3:0]        w_nibble;
   logic [SEG_W-1:0]  w_glyph;
   logic [DIGITS-1:0] w_upper_zero;
   logic              w_blank;
   logic [DIGITS-1:0] w_anode_onehot;

   assign w_slot_end     = (r_slot_cnt == SLOT_LAST);
   assign w_boundary     = w_slot_end && (r_digit_idx == IDX_LAST);
   assign w_ghost        = (r_slot_cnt < SLOT_GHOST);
   assign w_anode_onehot = DIGITS'(1) << r_digit_idx;

   // Nibble of the display register for the digit currently being scanned.
   always_comb begin
      w_nibble = 4'h0;
      for (int unsigned k = 0; k < DIGITS; k++) begin
         if (r_digit_idx == IDX_W'(k)) begin
            w_nibble = r_display[4*k +: 4];
         end
      end
   end

   // w_upper_zero[k]: digits k..DIGITS-1 are all zero (invalid nibbles are nonzero).
   always_comb begin
      w_upper_zero = '0;
      for (int unsigned k = 0; k < DIGITS; k++) begin
         w_upper_zero[k] = ((r_display >> (4*k)) == '0);
      end
   end

   // Units digit always shows, so a zero value still displays "0".
   assign w_blank = LZBlank_i && (r_digit_idx != '0) && w_upper_zero[r_digit_idx];

   bcd_segment_decoder u_decoder (
      .i_nibble  (w_nibble),
      .o_glyph_c (w_glyph)
   );

   // Scan counters, load buffering and registered display outputs.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         r_slot_cnt      <= '0;
         r_digit_idx     <= '0;
         r_pending       <= '0;
         r_pending_valid <= 1'b0;
         r_display       <= '0;
         r_anodes        <= '0;
         r_segments      <= SEG_OFF;
         r_update        <= 1'b0;
      end else begin
         if (w_slot_end) begin
            r_slot_cnt  <= '0;
            r_digit_idx <= (r_digit_idx == IDX_LAST) ? '0 : r_digit_idx + IDX_W'(1);
         end else begin
            r_slot_cnt  <= r_slot_cnt + SLOT_W'(1);
         end

         // A load landing on the boundary itself bypasses the pending register.
         r_update <= 1'b0;
         if (w_boundary) begin
            if (Load_i) begin
               r_display <= BCD_i;
               r_update  <= 1'b1;
            end else if (r_pending_valid) begin
               r_display <= r_pending;
               r_update  <= 1'b1;
            end
            r_pending_valid <= 1'b0;
         end else if (Load_i) begin
            r_pending       <= BCD_i;
            r_pending_valid <= 1'b1;
         end

         if (w_ghost) begin
            r_anodes   <= '0;
            r_segments <= SEG_OFF;
         end else begin
            r_anodes   <= w_anode_onehot;
            r_segments <= w_blank ? SEG_OFF : w_glyph;
         end
      end
   end

   assign Anodes_o   = r_anodes;
   assign Segments_o = r_segments;
   assign Update_o   = r_update;

endmodule

// File: doc/bcd_display_mux.md
Name: bcd_display_mux

Overview:
- Consumes the 5-digit packed BCD word from the binary-to-BCD converter and drives a time-multiplexed common-anode/segment 7-segment display.
- Buffers new values and applies them only at a scan-frame boundary, so a digit never changes mid-frame.
- Provides leading-zero blanking and a dash glyph for invalid nibbles.
- Sits between the combinational BCD converter and the board display pins.

Parameters:
DIGITS, 5, number of BCD digits and anode lines
DIGIT_CYCLES, 200, clock cycles per digit slot (1 MHz clock gives a 1 kHz frame)
GHOST_CYCLES, 4, cycles at start of each slot with all anodes off (anti-ghosting); must be < DIGIT_CYCLES

Ports:
Clock  input  1  system clock
Reset  input  1  synchronous, active-high reset
BCD_i  input  4*DIGITS  packed BCD, digit 0 (units) in [3:0]
Load_i  input  1  one-cycle strobe; captures BCD_i into the pending register
LZBlank_i  input  1  1 = suppress leading zeros
Anodes_o  output  DIGITS  one-hot digit enable, active-high
Segments_o  output  7  {g,f,e,d,c,b,a}, active-high
Update_o  output  1  one-cycle pulse: new value applied to the display register

Behaviour:
- One clock domain. Reset is synchronous and active-high, sampled on posedge Clock with priority over everything.
- Reset values:
  - SlotCnt=0, DigitIdx=0, Pending=0, PendingValid=0, Display=0.
  - Anodes_o=0, Segments_o=0, Update_o=0.
- Counters:
  - SlotCnt counts 0..DIGIT_CYCLES-1, then wraps to 0.
  - On wrap, DigitIdx increments, wrapping DIGITS-1 -> 0.
- Frame boundary: the cycle with SlotCnt=DIGIT_CYCLES-1 and DigitIdx=DIGITS-1.
- Load handling:
  - Load_i=1 on a non-boundary cycle: Pending<=BCD_i, PendingValid<=1. Back-to-back loads: last wins.
  - Boundary with Load_i=1: Display<=BCD_i directly, which forwards past Pending. PendingValid<=0. Update_o=1 next cycle.
  - Boundary with Load_i=0 and PendingValid=1: Display<=Pending, PendingValid<=0, Update_o=1 next cycle.
  - Boundary with neither: Display is unchanged and no pulse is issued.
- Outputs are registered and derived from the current SlotCnt/DigitIdx/Display, so they lag the counters by one cycle.
  - If SlotCnt<GHOST_CYCLES: Anodes_o=0 and Segments_o=0.
  - Otherwise: Anodes_o=1<<DigitIdx and Segments_o=decode(Display digit DigitIdx).
- Decode:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F (hex).
  - Nibbles 10..15 decode to dash 40.
- Leading-zero blanking, when LZBlank_i=1:
  - Digit k>0 is blanked (Segments_o=0, anode still driven) if digits k..DIGITS-1 are all 0.
  - Digit 0 is never blanked.
  - An invalid nibble counts as nonzero.
  - LZBlank_i is sampled live, with no frame alignment.
- After reset release, Anodes_o stays 0 for GHOST_CYCLES+1 cycles, then enables digit 0 for DIGIT_CYCLES-GHOST_CYCLES cycles.
- Reset mid-frame: counters restart at digit 0 and the pending load is discarded.
- Display keeps showing 00000, shown as blank-blank-blank-blank-0 with LZB, until the first boundary after a load.

Decomposition:
- Shared package holds:
  - Segment glyph constants (SEG_0..SEG_9, SEG_DASH, SEG_OFF).
  - The default DIGITS value.
- One natural combinational sub-module: bcd_segment_decoder (4-bit nibble -> 7-bit glyph, dash for >9).
- Counters, pending/display registers and blanking logic stay in bcd_display_mux.

Test Plan:
- Use DIGITS=5, DIGIT_CYCLES=8, GHOST_CYCLES=2 for all scenarios.
- Reset, then idle two frames -> Anodes_o cycles 01,02,04,08,10. Each is held 6 cycles after 2 all-off cycles. Segments 3F on every digit (LZBlank_i=0). Update_o never pulses.
- Load_i with BCD_i=0x12345 mid-frame -> no change until the boundary. Then Update_o pulses once. The next frame shows digit0=6D, digit1=66, digit2=4F, digit3=5B, digit4=06.
- Load 0x00042 with LZBlank_i=1 -> digits 4,3,2 produce Segments_o=00 while their anodes are still driven. Digit1=66, digit0=5B. Load 0x00000 -> only digit0 shows 3F.
- Load 0x11111 then 0x22222 on consecutive cycles -> one Update_o. The display shows all 5B.
- Load_i of 0x0A0F0 asserted exactly on the boundary cycle -> applied immediately, Update_o the next cycle. Digits 1 and 3 show 40. With LZBlank_i=1, digit4 is blank and digit2/digit0 show 3F.
- Load 0x99999, assert Reset mid-frame before the boundary -> all outputs 0 the next cycle. The scan restarts at digit 0, the pending value is discarded, and no Update_o is issued.
